// File: rtl/shift_arbiter_if.sv
// Request/response bundle for shift_arbiter. Requesters and the result consumer sit
// on the master side, and the arbiter sits on the slave side.
interface shift_arbiter_if #(
  parameter int N = 32,
  parameter int M = $clog2(N)
) ();
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [1:0]   req_op0;
  logic [1:0]   req_op1;
  logic [N-1:0] req_a0;
  logic [N-1:0] req_a1;
  logic [M-1:0] req_amt0;
  logic [M-1:0] req_amt1;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [N-1:0] rsp_data;
  logic         busy;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_amt0, req_amt1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_amt0, req_amt1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two requesters share one iterative shifter/rotator that moves 1 bit per cycle.
// Access is granted round-robin, and a result is held until the consumer takes it.
module shift_arbiter #(
  parameter int N = 32,
  parameter int M = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t       state_r;
  state_t       state_nx_s;
  logic [N-1:0] acc_r;
  logic [M-1:0] cnt_r;
  logic [1:0]   op_r;
  logic         id_r;
  logic         last_grant_r;
  logic [1:0]   arb_s;
  logic [1:0]   grant_s;

  function automatic logic [N-1:0] shift_step(input logic [1:0] op, input logic [N-1:0] v);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = {v[0], v[N-1:1]};
      2'b01:   r = {v[N-2:0], v[N-1]};
      2'b10:   r = {1'b0, v[N-1:1]};
      2'b11:   r = {v[N-1], v[N-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Round-robin pick: on contention the requester that did not win last time wins now
  always_comb begin
    arb_s = 2'b00;
    if (bus.req_valid == 2'b11) begin
      arb_s = last_grant_r ? 2'b01 : 2'b10;
    end else begin
      arb_s = bus.req_valid;
    end
  end

  // Next-state and grant decode
  always_comb begin
    state_nx_s = state_r;
    grant_s    = 2'b00;
    case (state_r)
      IDLE: begin
        grant_s = arb_s;
        if (arb_s != 2'b00) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {M{1'b0}}) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operation capture at acceptance, then one shift step per RUN cycle until cnt reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r        <= {N{1'b0}};
      cnt_r        <= {M{1'b0}};
      op_r         <= 2'b00;
      id_r         <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (state_r == IDLE && grant_s != 2'b00) begin
      id_r         <= grant_s[1];
      last_grant_r <= grant_s[1];
      if (grant_s[1]) begin
        acc_r <= bus.req_a1;
        cnt_r <= bus.req_amt1;
        op_r  <= bus.req_op1;
      end else begin
        acc_r <= bus.req_a0;
        cnt_r <= bus.req_amt0;
        op_r  <= bus.req_op0;
      end
    end else if (state_r == RUN && cnt_r != {M{1'b0}}) begin
      acc_r <= shift_step(op_r, acc_r);
      cnt_r <= cnt_r - M'(1);
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  assign bus.req_ready = grant_s & {2{rst_n}};
  assign bus.rsp_valid = (state_r == DONE);
  assign bus.rsp_data  = acc_r;
  assign bus.rsp_id    = id_r;
  assign bus.busy      = (state_r != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a table of single-requester operations plus
// hand-written round-robin, back-pressure and mid-operation reset sequences.
module tb_shift_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   viol_11;

  shift_arbiter_if #(.N(32)) bus ();

  shift_arbiter #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.req_ready == 2'b11) viol_11++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int early;
    int lim;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    if (v.id) begin
      bus.req_op1 = v.op; bus.req_a1 = v.a; bus.req_amt1 = v.amt;
      bus.req_valid = 2'b10;
    end else begin
      bus.req_op0 = v.op; bus.req_a0 = v.a; bus.req_amt0 = v.amt;
      bus.req_valid = 2'b01;
    end
    #1;
    chk($sformatf("v%0d_ready", idx), {30'd0, bus.req_ready}, v.id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request inputs: the in-flight operation must ignore them
    bus.req_valid = 2'b00;
    bus.req_a0 = ~bus.req_a0; bus.req_a1 = ~bus.req_a1;
    bus.req_op0 = ~bus.req_op0; bus.req_op1 = ~bus.req_op1;
    bus.req_amt0 = ~bus.req_amt0; bus.req_amt1 = ~bus.req_amt1;
    chk($sformatf("v%0d_busy", idx), {31'd0, bus.busy}, 32'd1);
    early = 0;
    lim = int'(v.amt) + 1;
    for (int k = 1; k <= lim; k++) begin
      @(posedge clk);
      #1;
      if (k < lim && bus.rsp_valid) early++;
    end
    chk($sformatf("v%0d_early", idx), early, 32'd0);
    chk($sformatf("v%0d_valid", idx), {31'd0, bus.rsp_valid}, 32'd1);
    chk($sformatf("v%0d_data", idx), bus.rsp_data, v.exp);
    chk($sformatf("v%0d_id", idx), {31'd0, bus.rsp_id}, {31'd0, v.id});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_idle", idx), {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    int no_rsp;
    n_tests = 0; n_fail = 0; viol_11 = 0;
    vecs[0]  = '{1'b0, 2'b00, 32'h00000001, 5'd1,  32'h80000000};
    vecs[1]  = '{1'b1, 2'b11, 32'h80000000, 5'd4,  32'hF8000000};
    vecs[2]  = '{1'b1, 2'b10, 32'h80000000, 5'd4,  32'h08000000};
    vecs[3]  = '{1'b1, 2'b01, 32'h80000001, 5'd1,  32'h00000003};
    vecs[4]  = '{1'b0, 2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
    vecs[5]  = '{1'b0, 2'b01, 32'h12345678, 5'd4,  32'h23456781};
    vecs[6]  = '{1'b1, 2'b00, 32'h12345678, 5'd8,  32'h78123456};
    vecs[7]  = '{1'b0, 2'b10, 32'hFFFFFFFF, 5'd31, 32'h00000001};
    vecs[8]  = '{1'b1, 2'b11, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    vecs[9]  = '{1'b0, 2'b11, 32'h80000000, 5'd31, 32'hFFFFFFFF};
    vecs[10] = '{1'b1, 2'b01, 32'h80000000, 5'd31, 32'h40000000};

    rst_n = 1'b0;
    bus.req_valid = 2'b11; bus.rsp_ready = 1'b0;
    bus.req_op0 = 2'b00; bus.req_op1 = 2'b00;
    bus.req_a0 = 32'hA0A0A0A0; bus.req_a1 = 32'hB1B1B1B1;
    bus.req_amt0 = 5'd0; bus.req_amt1 = 5'd0;
    #2;
    chk("rst_ready", {30'd0, bus.req_ready}, 32'd0);
    chk("rst_outs", {29'd0, bus.rsp_valid, bus.rsp_id, bus.busy}, 32'd0);
    chk("rst_data", bus.rsp_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // Both requesters held valid: the first grant goes to 0, then they alternate
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("rr%0d_ready", i), {30'd0, bus.req_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_run", i), {30'd0, bus.req_ready, bus.busy}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d_id", i), {30'd0, bus.rsp_valid, bus.rsp_id}, (i % 2 == 0) ? 32'd2 : 32'd3);
      chk($sformatf("rr%0d_data", i), bus.rsp_data, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      @(posedge clk);
    end
    #1;
    bus.req_valid = 2'b00;
    @(posedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-pressure: the result is held while rsp_ready is low, and requester 1 is stalled
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_op0 = 2'b01; bus.req_a0 = 32'h0000000F; bus.req_amt0 = 5'd2;
    bus.req_op1 = 2'b00; bus.req_a1 = 32'h00000001; bus.req_amt1 = 5'd0;
    bus.req_valid = 2'b01;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b10;
    repeat (3) @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_ctl", c), {28'd0, bus.req_ready, bus.rsp_valid, bus.busy}, 32'd3);
      chk($sformatf("hold%0d_data", c), bus.rsp_data, 32'h0000003C);
      chk($sformatf("hold%0d_id", c), {31'd0, bus.rsp_id}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
    chk("stalled_grant", {30'd0, bus.req_ready}, 32'd2);
    bus.req_valid = 2'b00;
    @(posedge clk);

    // Reset asserted between clock edges during a long operation
    @(negedge clk);
    bus.req_op1 = 2'b00; bus.req_a1 = 32'hDEADBEEF; bus.req_amt1 = 5'd20;
    bus.req_valid = 2'b10;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    bus.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", {27'd0, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.busy}, 32'd0);
    chk("mid_rst_data", bus.rsp_data, 32'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    no_rsp = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.busy) no_rsp++;
    end
    chk("post_rst_quiet", no_rsp, 32'd0);
    chk("never_11", viol_11, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter N, default 32: operand/result width in bits.
REQ-002 Parameter M, default $clog2(N): shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept; at most one bit high.
REQ-007 req_op0, req_op1  input  2 each  op code per requester: 00 ROR, 01 ROL, 10 LSR, 11 ASR.
REQ-008 req_a0, req_a1  input  N each  operand per requester.
REQ-009 req_amt0, req_amt1  input  M each  shift/rotate amount per requester.
REQ-010 rsp_valid  output  1  result valid.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  1  requester index owning rsp_data.
REQ-013 rsp_data  output  N  result.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 The block SHALL share one iterative 1-bit-per-cycle shifter/rotator between two requesters via FSM states IDLE, RUN, DONE.
REQ-016 In IDLE, req_ready SHALL be combinational: grant bit i high iff req_valid[i] high and requester i wins arbitration; zero in RUN and DONE.
REQ-017 Arbitration SHALL be round-robin: single valid requester wins; both valid -> requester other than last_grant wins.
REQ-018 last_grant SHALL update only on an accepted request (req_valid[i] & req_ready[i]).
REQ-019 On acceptance: latch op, acc <= operand, cnt <= amt, id <= i, state -> RUN.
REQ-020 In RUN with cnt != 0: acc shifts one bit per op, cnt decrements by 1.
REQ-021 ROR: acc <= {acc[0], acc[N-1:1]}; ROL: acc <= {acc[N-2:0], acc[N-1]}; LSR: {1'b0, acc[N-1:1]}; ASR: {acc[N-1], acc[N-1:1]}.
REQ-022 In RUN with cnt == 0: state -> DONE, acc unchanged.
REQ-023 Latency: rsp_valid SHALL rise exactly amt+1 rising edges after the acceptance edge (amt=0 -> 1 edge).
REQ-024 In DONE: rsp_valid=1, rsp_data=acc, rsp_id=id, all held stable until rsp_ready sampled high.
REQ-025 DONE with rsp_ready=1 -> IDLE on that edge; new request accepted no earlier than the following cycle.
REQ-026 rsp_valid SHALL be 0 outside DONE; rsp_data/rsp_id are don't-care there but SHALL not contain X after reset.
REQ-027 Requests arriving in RUN/DONE SHALL be stalled (req_ready=0), not dropped; requester holds inputs.
REQ-028 Request inputs SHALL be sampled only at the acceptance edge; later changes do not affect the in-flight operation.
REQ-029 Amount width M SHALL limit shifts to 0..N-1; no wrap or saturation logic required.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, acc=0, cnt=0, id=0, last_grant=1, independent of clk.
REQ-031 Reset outputs: req_ready=00 (while rst_n low), rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
REQ-032 Reset during RUN or DONE SHALL abort the operation; no response issued after reset release.
REQ-033 First arbitration after reset with both requesters valid SHALL grant requester 0.

Verification
REQ-034 Req0 ROR a=0x00000001 amt=1, rsp_ready=1 -> rsp_valid 2 edges after accept, rsp_data=0x80000000, rsp_id=0.
REQ-035 Req1 ASR a=0x80000000 amt=4 -> rsp_data=0xF8000000 after 5 edges; LSR same input -> 0x08000000; ROL 0x80000001 amt=1 -> 0x00000003.
REQ-036 Req0 LSL-free check: amt=0 ROR a=0xDEADBEEF -> rsp_data=0xDEADBEEF after 1 edge.
REQ-037 Both req_valid held high for 4 operations after reset -> grant order 0,1,0,1; req_ready never 11.
REQ-038 DONE with rsp_ready low 5 cycles -> rsp_valid/rsp_data/rsp_id stable, req_ready=00, busy=1; IDLE after rsp_ready high.
REQ-039 rst_n pulsed low mid-RUN (amt=20, cycle 7) -> outputs at reset values asynchronously, no rsp_valid afterwards until a new request.
